prog_loader: RTL and testbench

//  Writer side of the program memory. Receives a byte stream (host/UART

---
 rtl/prog_loader.sv | 176 +++++++++++++++++
 tb/tb_prog_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader
// Brief   : Assembles a header-prefixed little-endian byte stream into 32-bit
//           words and writes them into the instruction RAM, holding the CPU
//           until the complete image is in place.
// Revision: 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int WIDTH  = 32,
    parameter int LENGTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_hold,
    output logic [15:0]      words_written
);

    localparam logic [15:0] c_LENGTH = 16'(LENGTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_n_lo;
    logic [15:0]      r_n;
    logic [1:0]       r_idx;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [15:0]      r_words;

    logic [15:0]      w_hdr_n;
    logic [15:0]      w_words_inc;
    logic             w_restart;
    logic [WIDTH-1:0] w_word;

    assign w_hdr_n     = {rx_data, r_n_lo};
    assign w_words_inc = r_words + 16'd1;
    assign w_restart   = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERR));

    // The final byte is merged on the fly so the word is ready the same edge.
    always_comb begin
        w_word = r_asm;
        w_word[24 +: 8] = rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_HDR0;
            end
            S_HDR0: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) w_next = S_HDR1;
            end
            S_HDR1: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    if (w_hdr_n == 16'd0)          w_next = S_DONE;
                    else if (w_hdr_n > c_LENGTH)   w_next = S_ERR;
                    else                           w_next = S_DATA;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid && (r_idx == 2'd3)) w_next = S_WRITE;
            end
            S_WRITE: begin
                // A reset landing on the write cycle must not reach the RAM.
                mem_we = ~rst;
                busy   = 1'b1;
                if (w_words_inc == r_n) w_next = S_DONE;
                else                    w_next = S_DATA;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) w_next = S_HDR0;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) w_next = S_HDR0;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_lo  <= '0;
            r_n     <= '0;
            r_idx   <= '0;
            r_asm   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_words <= '0;
        end else begin
            if (w_restart) begin
                r_words <= '0;
                r_addr  <= '0;
                r_idx   <= '0;
            end
            case (r_state)
                S_HDR0: begin
                    if (rx_valid) r_n_lo <= rx_data;
                end
                S_HDR1: begin
                    if (rx_valid) r_n <= w_hdr_n;
                end
                S_DATA: begin
                    if (rx_valid) begin
                        if (r_idx == 2'd3) begin
                            r_wdata <= w_word;
                            r_idx   <= 2'd0;
                        end else begin
                            r_asm[8*r_idx +: 8] <= rx_data;
                            r_idx               <= r_idx + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    r_addr  <= r_addr + WIDTH'(4);
                    r_words <= w_words_inc;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign words_written = r_words;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_loader
// Brief   : Self-checking bench for prog_loader against a word-image model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int WIDTH  = 32;
    localparam int LENGTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;
    logic [15:0] words_written;

    prog_loader #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .error(error), .cpu_hold(cpu_hold),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rdy_viol = 0;
    logic [63:0] wq[$];
    int          tq[$];
    logic [31:0] img [0:LENGTH-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every RAM write seen mid-cycle, plus its cycle number.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq.push_back({mem_addr, mem_wdata});
            tq.push_back(cyc);
            if (rx_ready !== 1'b0) rdy_viol++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bubbles);
        bit acc;
        if (bubbles) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                tick();
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = (rx_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout: rx_ready never high, required 1");
        end
    endtask

    task automatic send_image(input int n, input bit bubbles);
        send_byte(8'(n), bubbles);
        send_byte(8'(n >> 8), bubbles);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++)
                send_byte(img[i][8*k +: 8], bubbles);
        rx_valid = 1'b0;
    endtask

    task automatic fill_image(input int n);
        for (int i = 0; i < n; i++) img[i] = $urandom;
    endtask

    task automatic wait_end();
        for (int t = 0; t < 20; t++) begin
            if (done === 1'b1 || error === 1'b1) break;
            tick();
        end
        if (done !== 1'b1 && error !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL load_end_timeout: done=%b error=%b, required one high", done, error);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({rx_ready, mem_we, busy, done, error, cpu_hold} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_flags: got %b, required 000001",
                     {rx_ready, mem_we, busy, done, error, cpu_hold});
        end
        checks++;
        if ({mem_addr, mem_wdata, words_written} !== 80'd0) begin
            failures++;
            $display("FAIL reset_data: addr=%h wdata=%h words=%0d, required all 0",
                     mem_addr, mem_wdata, words_written);
        end
    endtask

    task automatic test_basic();
        img[0] = 32'h12345678;
        img[1] = 32'hDEADBEEF;
        wq.delete();
        do_start();
        send_image(2, 1'b0);
        wait_end();
        checks++;
        if (wq.size() !== 2) begin
            failures++;
            $display("FAIL basic_count: got %0d writes, required 2", wq.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wq[i] !== {32'(4*i), img[i]}) begin
                    failures++;
                    $display("FAIL basic_write%0d: got %h, required %h", i, wq[i], {32'(4*i), img[i]});
                end
            end
        end
        checks++;
        if ({done, cpu_hold, words_written} !== {1'b1, 1'b0, 16'd2}) begin
            failures++;
            $display("FAIL basic_status: done=%b hold=%b words=%0d, required 1 0 2",
                     done, cpu_hold, words_written);
        end
    endtask

    task automatic test_zero_len();
        wq.delete();
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        rx_valid = 1'b0;
        checks++;
        if ({done, busy, cpu_hold} !== 3'b100) begin
            failures++;
            $display("FAIL zero_len_done: done/busy/hold=%b, required 100", {done, busy, cpu_hold});
        end
        tick();
        checks++;
        if (wq.size() !== 0 || words_written !== 16'd0) begin
            failures++;
            $display("FAIL zero_len_writes: got %0d writes words=%0d, required 0", wq.size(), words_written);
        end
    endtask

    task automatic test_overflow();
        wq.delete();
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        rx_valid = 1'b1;
        tick();
        tick();
        rx_valid = 1'b0;
        checks++;
        if ({error, cpu_hold, rx_ready, done, busy} !== 5'b11000 || wq.size() !== 0) begin
            failures++;
            $display("FAIL overflow_err: err/hold/rdy/done/busy=%b writes=%0d, required 11000 0",
                     {error, cpu_hold, rx_ready, done, busy}, wq.size());
        end
        do_start();
        checks++;
        if ({busy, error, rx_ready} !== 3'b101) begin
            failures++;
            $display("FAIL overflow_restart: busy/err/rdy=%b, required 101", {busy, error, rx_ready});
        end
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        rx_valid = 1'b0;
    endtask

    task automatic test_random_valid();
        int n;
        for (int r = 0; r < 4; r++) begin
            n = (r == 0) ? 3 : int'($urandom_range(1, 8));
            fill_image(n);
            wq.delete();
            rdy_viol = 0;
            do_start();
            send_image(n, 1'b1);
            wait_end();
            checks++;
            if (wq.size() !== n) begin
                failures++;
                $display("FAIL rand%0d_count: got %0d writes, required %0d", r, wq.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (wq[i] !== {32'(4*i), img[i]}) begin
                        failures++;
                        $display("FAIL rand%0d_write%0d: got %h, required %h", r, i, wq[i], {32'(4*i), img[i]});
                    end
                end
            end
            checks++;
            if ({done, words_written} !== {1'b1, 16'(n)} || rdy_viol !== 0) begin
                failures++;
                $display("FAIL rand%0d_status: done=%b words=%0d rdy_in_write=%0d, required 1 %0d 0",
                         r, done, words_written, rdy_viol, n);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            fill_image(3);
            wq.delete();
            do_start();
            send_byte(8'h03, 1'b0);
            send_byte(8'h00, 1'b0);
            for (int k = 0; k < (c == 0 ? 2 : 4); k++) send_byte(img[0][8*k +: 8], 1'b0);
            rx_valid = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            checks++;
            if ({rx_ready, busy, done, error, cpu_hold} !== 5'b00001 || wq.size() !== 0 ||
                {mem_addr, mem_wdata, words_written} !== 80'd0) begin
                failures++;
                $display("FAIL rst_mid%0d: flags=%b writes=%0d addr=%h wdata=%h words=%0d, required 00001 0 0 0 0",
                         c, {rx_ready, busy, done, error, cpu_hold}, wq.size(), mem_addr, mem_wdata, words_written);
            end
        end
        fill_image(2);
        wq.delete();
        do_start();
        send_image(2, 1'b0);
        wait_end();
        checks++;
        if (wq.size() !== 2 || wq[0] !== {32'd0, img[0]} || wq[1] !== {32'd4, img[1]}) begin
            failures++;
            $display("FAIL rst_reload: got %0d writes first=%h, required 2 first=%h",
                     wq.size(), (wq.size() > 0) ? wq[0] : 64'd0, {32'd0, img[0]});
        end
    endtask

    task automatic test_start_ignored();
        fill_image(3);
        wq.delete();
        do_start();
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (i == 1 && k == 1) begin
                    rx_valid = 1'b0;
                    do_start();
                end
                send_byte(img[i][8*k +: 8], 1'b0);
            end
        end
        rx_valid = 1'b0;
        wait_end();
        checks++;
        if (wq.size() !== 3) begin
            failures++;
            $display("FAIL start_ign_count: got %0d writes, required 3", wq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wq[i] !== {32'(4*i), img[i]}) begin
                    failures++;
                    $display("FAIL start_ign_write%0d: got %h, required %h", i, wq[i], {32'(4*i), img[i]});
                end
            end
        end
    endtask

    task automatic test_full_length();
        int bad;
        int slow;
        fill_image(LENGTH);
        wq.delete();
        tq.delete();
        do_start();
        send_image(LENGTH, 1'b0);
        wait_end();
        checks++;
        if (wq.size() !== LENGTH) begin
            failures++;
            $display("FAIL full_count: got %0d writes, required %0d", wq.size(), LENGTH);
        end else begin
            bad  = 0;
            slow = 0;
            for (int i = 0; i < LENGTH; i++) begin
                if (wq[i] !== {32'(4*i), img[i]}) bad++;
                if (i > 0 && (tq[i] - tq[i-1]) != 5) slow++;
            end
            checks++;
            if (bad !== 0 || wq[LENGTH-1][63:32] !== 32'(4*(LENGTH-1))) begin
                failures++;
                $display("FAIL full_data: %0d bad words last_addr=%h, required 0 and %h",
                         bad, wq[LENGTH-1][63:32], 32'(4*(LENGTH-1)));
            end
            checks++;
            if (slow !== 0) begin
                failures++;
                $display("FAIL full_rate: %0d word gaps not 5 cycles, required 0", slow);
            end
        end
        checks++;
        if ({done, words_written} !== {1'b1, 16'(LENGTH)}) begin
            failures++;
            $display("FAIL full_status: done=%b words=%0d, required 1 %0d", done, words_written, LENGTH);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_random_valid();
        test_reset_mid();
        test_start_ignored();
        test_full_length();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
